// File: rtl/ula_sequenciador.sv
// Command sequencer for the external 4-bit ALU: register file, C/V flags,
// single-cycle ALU ops, LDI, and a fixed-latency shift-and-add MUL.
module ula_sequenciador #(
   parameter int W    = 4,
   parameter int NREG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_op,
   input  logic [1:0]   cmd_rd,
   input  logic [1:0]   cmd_ra,
   input  logic [1:0]   cmd_rb,
   input  logic [W-1:0] cmd_imm,
   output logic [W-1:0] alu_A,
   output logic [W-1:0] alu_B,
   output logic         alu_Cin,
   output logic [2:0]   alu_seletor,
   input  logic [W-1:0] alu_resultado,
   input  logic         alu_Cout,
   output logic         done,
   output logic         erro,
   output logic [W-1:0] res,
   output logic         carry,
   output logic         ovf,
   input  logic [1:0]   dbg_sel,
   output logic [W-1:0] dbg_data
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL_ADD, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [3:0]     r_op;
   logic [1:0]     r_rd;
   logic [W-1:0]   r_av;
   logic [W-1:0]   r_bv;
   logic [W-1:0]   r_imm;
   logic [1:0]     r_i;
   logic [W-1:0]   r_acc;
   logic [W-1:0]   r_regs [NREG];
   logic           r_c;
   logic           r_v;
   logic [W-1:0]   r_res;

   logic           w_accept;
   logic [2*W-1:0] w_wide;
   logic [W-1:0]   w_mc;
   logic           w_lost;
   logic           w_bit;
   logic [W-1:0]   w_acc_next;

   assign w_accept   = (r_state == S_IDLE) && cmd_valid;
   // Multiplicand shifted by i; any bit pushed above W means the product overflows
   assign w_wide     = {{W{1'b0}}, r_av} << r_i;
   assign w_mc       = w_wide[W-1:0];
   assign w_lost     = |w_wide[2*W-1:W];
   assign w_bit      = r_bv[r_i];
   assign w_acc_next = w_bit ? alu_resultado : r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_next = (cmd_op == 4'd9) ? S_MUL_ADD : S_EXEC;
         S_EXEC:    w_next = S_DONE;
         S_MUL_ADD: if (r_i == 2'd3) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready   = (r_state == S_IDLE) && rst_n;
      done        = (r_state == S_DONE);
      erro        = (r_state == S_DONE) && (r_op >= 4'd10);
      alu_A       = '0;
      alu_B       = '0;
      alu_Cin     = 1'b0;
      alu_seletor = 3'b000;
      if (r_state == S_EXEC && !r_op[3]) begin
         alu_A       = r_av;
         alu_B       = r_bv;
         alu_Cin     = r_c;
         alu_seletor = r_op[2:0];
      end else if (r_state == S_MUL_ADD) begin
         alu_A       = r_acc;
         alu_B       = w_mc;
         alu_seletor = 3'b100;
      end
   end

   // Operands are captured at accept so rd may alias ra/rb during MUL
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= '0;
         r_rd  <= '0;
         r_av  <= '0;
         r_bv  <= '0;
         r_imm <= '0;
         r_i   <= '0;
         r_acc <= '0;
         r_c   <= 1'b0;
         r_v   <= 1'b0;
         r_res <= '0;
         for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_op  <= cmd_op;
               r_rd  <= cmd_rd;
               r_av  <= r_regs[cmd_ra];
               r_bv  <= r_regs[cmd_rb];
               r_imm <= cmd_imm;
               r_v   <= 1'b0;
               r_acc <= '0;
               r_i   <= '0;
            end
            S_EXEC: begin
               if (!r_op[3]) begin
                  r_regs[r_rd] <= alu_resultado;
                  r_res        <= alu_resultado;
                  if (r_op == 4'd4) r_c <= alu_Cout;
               end else if (r_op == 4'd8) begin
                  r_regs[r_rd] <= r_imm;
                  r_res        <= r_imm;
               end
            end
            S_MUL_ADD: begin
               r_acc <= w_acc_next;
               r_i   <= r_i + 2'd1;
               if (w_bit) r_v <= r_v | alu_Cout | w_lost;
               if (r_i == 2'd3) begin
                  r_regs[r_rd] <= w_acc_next;
                  r_res        <= w_acc_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign res      = r_res;
   assign carry    = r_c;
   assign ovf      = r_v;
   assign dbg_data = r_regs[dbg_sel];

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador: behavioural ALU attached to the ALU ports and an
// arithmetic reference model of the register file and flags.
module tb_ula_sequenciador;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [1:0] cmd_rd, cmd_ra, cmd_rb;
   logic [3:0] cmd_imm;
   logic [3:0] alu_A, alu_B;
   logic       alu_Cin;
   logic [2:0] alu_seletor;
   logic [3:0] alu_resultado;
   logic       alu_Cout;
   logic       done, erro;
   logic [3:0] res;
   logic       carry, ovf;
   logic [1:0] dbg_sel;
   logic [3:0] dbg_data;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int acc_cyc;
   int m_r [4];
   int m_c, m_v, m_res;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ula_sequenciador #(.W(4), .NREG(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
      .cmd_imm(cmd_imm), .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin),
      .alu_seletor(alu_seletor), .alu_resultado(alu_resultado), .alu_Cout(alu_Cout),
      .done(done), .erro(erro), .res(res), .carry(carry), .ovf(ovf),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   // Behavioural ALU; Cout is deliberately nonzero garbage outside ADD
   logic [4:0] alu_sum;
   assign alu_sum = {1'b0, alu_A} + {1'b0, alu_B} + {4'b0, alu_Cin};
   always_comb begin
      alu_Cout = alu_A[0] | alu_B[0];
      case (alu_seletor)
         3'd0: alu_resultado = alu_A & alu_B;
         3'd1: alu_resultado = alu_A | alu_B;
         3'd2: alu_resultado = ~alu_A;
         3'd3: alu_resultado = ~(alu_A & alu_B);
         3'd4: begin alu_resultado = alu_sum[3:0]; alu_Cout = alu_sum[4]; end
         3'd5: alu_resultado = alu_A - alu_B;
         3'd6: alu_resultado = alu_A ^ alu_B;
         default: alu_resultado = alu_A;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int ref_alu(input int op, input int a, input int b, input int cin,
                                  output int co);
      int s;
      co = 0;
      case (op)
         0: s = a & b;
         1: s = a | b;
         2: s = 15 - a;
         3: s = 15 - (a & b);
         4: begin s = a + b + cin; co = (s > 15) ? 1 : 0; end
         5: s = a - b + 16;
         6: s = a ^ b;
         default: s = a;
      endcase
      return s % 16;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_r[k] = 0;
      m_c = 0; m_v = 0; m_res = 0;
   endtask

   task automatic check_regs(input string tag);
      for (int k = 0; k < 4; k++) begin
         dbg_sel = 2'(k);
         #1 chk(tag, dbg_data, m_r[k]);
      end
   endtask

   task automatic run_cmd(input int op, input int rd, input int ra, input int rb,
                          input int imm, input bit keep = 1'b0);
      int  a, b, co, lat_exp, n;
      bit  ill;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      chk("ready_before_cmd", cmd_ready, 1);
      chk("alu_idle", {alu_A, alu_B, alu_Cin, alu_seletor}, 0);
      cmd_valid = 1'b1;
      cmd_op = 4'(op); cmd_rd = 2'(rd); cmd_ra = 2'(ra); cmd_rb = 2'(rb); cmd_imm = 4'(imm);
      a = m_r[ra]; b = m_r[rb];
      m_v = 0; ill = 1'b0; lat_exp = 2;
      if (op < 8) begin
         m_res = ref_alu(op, a, b, m_c, co);
         m_r[rd] = m_res;
         if (op == 4) m_c = co;
      end else if (op == 8) begin
         m_res = imm; m_r[rd] = imm;
      end else if (op == 9) begin
         m_res = (a * b) % 16; m_r[rd] = m_res;
         m_v = (a * b > 15) ? 1 : 0;
         lat_exp = 5;
      end else begin
         ill = 1'b1;
      end
      @(posedge clk);
      acc_cyc = cyc;
      if (!keep) #1 cmd_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 20);
      chk("latency", n, lat_exp);
      chk("done", done, 1);
      chk("erro", erro, ill);
      chk("res", res, m_res);
      chk("carry", carry, m_c);
      chk("ovf", ovf, m_v);
      check_regs("reg");
      @(negedge clk);
      chk("done_one_cycle", {done, erro}, 0);
   endtask

   initial begin
      int prev, bad, op;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
      cmd_rb = '0; cmd_imm = '0; dbg_sel = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_outs", {done, erro, res, carry, ovf}, 0);
      chk("rst_alu", {alu_A, alu_B, alu_Cin, alu_seletor}, 0);
      check_regs("rst_reg");
      rst_n = 1'b1;
      @(negedge clk);

      // add with carry, then carry propagating into Cin, then SUB keeping C
      run_cmd(8, 1, 0, 0, 9);
      run_cmd(8, 2, 0, 0, 8);
      run_cmd(4, 3, 1, 2, 0);
      run_cmd(4, 0, 1, 2, 0);
      run_cmd(5, 0, 1, 2, 0);

      // MUL corner cases
      run_cmd(8, 1, 0, 0, 3);  run_cmd(8, 2, 0, 0, 5);  run_cmd(9, 3, 1, 2, 0);
      run_cmd(8, 1, 0, 0, 4);  run_cmd(8, 2, 0, 0, 4);  run_cmd(9, 3, 1, 2, 0);
      run_cmd(8, 1, 0, 0, 15); run_cmd(8, 2, 0, 0, 1);  run_cmd(9, 3, 1, 2, 0);
      run_cmd(8, 1, 0, 0, 2);  run_cmd(8, 2, 0, 0, 3);  run_cmd(9, 1, 1, 2, 0);

      run_cmd(12, 0, 1, 2, 5);

      // reset in the middle of a MUL
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'd9; cmd_rd = 2'd0; cmd_ra = 2'd1; cmd_rb = 2'd2;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_outs", {done, erro, res, carry, ovf}, 0);
      chk("midrst_ready", cmd_ready, 0);
      chk("midrst_alu", {alu_A, alu_B, alu_Cin, alu_seletor}, 0);
      check_regs("midrst_reg");
      bad = 0;
      repeat (4) begin @(negedge clk); if (done) bad++; end
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); if (done) bad++; end
      chk("midrst_no_done", bad, 0);
      run_cmd(8, 2, 0, 0, 7);

      // valid held high, back-to-back logic ops
      run_cmd(8, 1, 0, 0, 10);
      run_cmd(8, 2, 0, 0, 6);
      for (int k = 0; k < 4; k++) begin
         prev = acc_cyc;
         run_cmd(k, 0, 1, 2, 0, 1'b1);
         if (k > 0) chk("accept_gap", acc_cyc - prev, 3);
      end
      cmd_valid = 1'b0;

      for (int k = 0; k < 60; k++) begin
         op = (k % 4 == 0) ? 8 : int'($urandom_range(0, 15));
         run_cmd(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "timeout");
   end

endmodule
